// File: rtl/axis_arb_pkg.sv
// Purpose : shared types and width helpers for the AXI4-stream arbiters.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
package axis_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Width of a source index; a single-port arbiter still carries a 1-bit tag.
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must be able to hold the value n itself.
  function automatic int count_w(input int n);
    return (n > 1) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Purpose : rotating-priority pick: first request at or after ptr+1, wrapping.
// Latency : combinational.
// Backpr. : none; the caller qualifies the pick with its own load/ready.
// Ports   : req    - request vector, one bit per port
//           ptr    - index of the last winner (lowest priority next time)
//           grant  - index of the winning port (0 when no request)
//           any_req- at least one request is present
module rr_priority_picker
  import axis_arb_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  localparam int SRC_W     = src_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [SRC_W-1:0]     ptr,
  output logic [SRC_W-1:0]     grant,
  output logic                 any_req
);

  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    // Walk the ports in priority order starting just past ptr; the inner loop
    // keeps every req bit select a constant index.
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!found && (i == idx) && req[i]) begin
          found = 1'b1;
          grant = SRC_W'(i);
        end
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/axis_rr_arbiter.sv
// Purpose : round-robin merge of NUM_PORTS AXI4-stream sources into one sink, beats tagged with source index.
// Latency : one cycle, single registered output stage; one beat per cycle sustained.
// Backpr. : m_valid && !m_ready holds the output and drops every s_ready; arbitration state frozen.
// Ports   : clk, rst (async, active high); s_data/s_valid/s_ready per source;
//           m_data/m_valid/m_ready/m_src toward the sink.
// Config  : define AXIS_ARB_BURST_EN to let a winner keep the grant for up to MAX_BURST beats.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  parameter  int DATA_SIZE = 8,
  parameter  int MAX_BURST = 4,
  localparam int SRC_W     = src_w(NUM_PORTS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS*DATA_SIZE-1:0] s_data,
  input  logic [NUM_PORTS-1:0]           s_valid,
  output logic [NUM_PORTS-1:0]           s_ready,
  output logic [DATA_SIZE-1:0]           m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [SRC_W-1:0]               m_src
);

  logic [SRC_W-1:0]     ptr;
  logic [SRC_W-1:0]     pick;
  logic [SRC_W-1:0]     grant;
  logic                 any_req;
  logic                 load;
  logic                 xfer;
  logic [DATA_SIZE-1:0] gdata;

  rr_priority_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .req     (s_valid),
    .ptr     (ptr),
    .grant   (pick),
    .any_req (any_req)
  );

  assign load = !m_valid || m_ready;
  // Whenever anything is valid the grant points at a valid port, so a load
  // cycle with any request is always a transfer.
  assign xfer = load && any_req && !rst;

`ifdef AXIS_ARB_BURST_EN
  localparam int COUNT_W = count_w(MAX_BURST);

  arb_state_t         state, state_nxt;
  logic [SRC_W-1:0]   owner, owner_nxt;
  logic [COUNT_W-1:0] count, count_nxt;
  logic               owner_vld;

  always_comb begin
    owner_vld = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (owner == SRC_W'(i)) owner_vld = s_valid[i];
    end
    // An owner that goes idle loses the lock immediately; the picker result
    // is used in the same cycle so no bubble is inserted.
    grant = (state == LOCK && owner_vld) ? owner : pick;
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    count_nxt = count;
    if (xfer) begin
      if (state == LOCK && owner_vld) begin
        if (count == COUNT_W'(MAX_BURST - 1)) begin
          state_nxt = ARB;
          count_nxt = '0;
        end else begin
          count_nxt = count + 1'b1;
        end
      end else if (MAX_BURST > 1) begin
        state_nxt = LOCK;
        owner_nxt = grant;
        count_nxt = COUNT_W'(1);
      end else begin
        state_nxt = ARB;
        count_nxt = '0;
      end
    end else if (load) begin
      state_nxt = ARB;
      count_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB;
      owner <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      count <= count_nxt;
    end
  end
`else
  assign grant = pick;
`endif

  always_comb begin
    gdata   = '0;
    s_ready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant == SRC_W'(i)) begin
        gdata      = s_data[i*DATA_SIZE +: DATA_SIZE];
        s_ready[i] = load && any_req && !rst;
      end
    end
  end

  // ptr resets to the last port so port 0 wins the first arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_src   <= '0;
      ptr     <= SRC_W'(NUM_PORTS - 1);
    end else if (xfer) begin
      m_valid <= 1'b1;
      m_data  <= gdata;
      m_src   <= grant;
      ptr     <= grant;
    end else if (load) begin
      m_valid <= 1'b0;
    end
  end

endmodule
